netbus_lane_packer: RTL
=======================

# netbus_lane_packer

Leaf-side NetBus source endpoint. It packs a narrow lane stream of one DATA_WIDTH lane per beat, delimited by LAST, into NetBus port words of DATA_WIDTH*9+14 bits and drives them onto a switch input port through a VALID/READY handshake. It sits between local user logic and a NetBusMUX-class switch input. It is the sending end of the port that the switch consumes.

## Interface
- DATA_WIDTH, 4, lane width in bits; a NetBus word carries 9 lanes.
- CLK  in  1  single clock for all logic.
- RESETn  in  1  asynchronous, active-low reset.
- S_DATA  in  DATA_WIDTH  lane payload.
- S_LAST  in  1  marks the final lane of a packet.
- S_DEST  in  8  destination address; sampled only on the first lane of a packet.
- S_VALID  in  1  lane valid.
- S_READY  out  1  lane accepted when S_VALID & S_READY.
- WDATA  out  DATA_WIDTH*9+14  NetBus word.
- WVALID  out  1  word valid.
- WREADY  in  1  word accepted when WVALID & WREADY.
- PKT_COUNT  out  16  count of packets fully sent (EOP words accepted); wraps.

## Operation
- Word format:
  - WDATA[13] = SOP.
  - WDATA[12] = EOP.
  - WDATA[11:8] = number of valid lanes minus 1 (0..8).
  - WDATA[7:0] = destination.
  - Lane k (0..8) occupies WDATA[14+DATA_WIDTH*(k+1)-1 : 14+DATA_WIDTH*k]. Lane 0 is the first lane received.
  - Unused lanes are 0.
- Two storage stages: an accumulator (9 lanes, 4-bit lane index, SOP flag, dest register) and an output register (WDATA/WVALID).
- Accumulator states:
  - IDLE (empty, start of packet): first accepted lane latches S_DEST into the dest register and sets SOP. Next state is FILL, or COMPLETE if S_LAST.
  - FILL (partial word): each accepted lane is written at the current index, and the index increments.
  - COMPLETE: entered when the lane at index 8 is accepted, or when a lane with S_LAST is accepted. EOP = S_LAST of that lane; count field = index of that lane.
- Transfer:
  - A COMPLETE accumulator moves to the output register in the same cycle it completes if the output register is empty, or if it is being drained that cycle (WVALID & WREADY). Otherwise it waits in COMPLETE.
  - After transfer the accumulator goes to IDLE if EOP, else to FILL with index 0 and SOP cleared. Dest is retained within a packet.
- S_READY = 1 unless the accumulator is in COMPLETE and waiting. S_READY is combinational from state only; it does not depend on S_VALID.
- PKT_COUNT increments by 1 on every accepted word with EOP=1. It wraps 0xFFFF -> 0x0000.
- A single-lane packet (S_LAST on the first lane) produces one word with SOP=1, EOP=1, count=0.
- S_DEST is ignored on every lane except the first lane of each packet.

## Timing
- Reset (RESETn low, asynchronous):
  - WVALID = 0, WDATA = 0, PKT_COUNT = 0.
  - Accumulator goes to IDLE, index 0.
  - S_READY = 1.
- Latency: the completing lane is accepted at edge N; WVALID = 1 with that word after edge N (visible cycle N+1), provided the output slot was free or draining.
- While WVALID = 1 and WREADY = 0, WDATA is held stable. WVALID is never retracted before acceptance.
- Sustained throughput: one lane per cycle, i.e. one word per 9 cycles for full words, with no S_READY bubbles as long as WREADY keeps up.
- Back-pressure: with the output register full and not draining, the accumulator may fill and reach COMPLETE. S_READY then drops the cycle after completion. It rises the cycle after WVALID & WREADY, which is also the edge on which the held word is loaded.
- Same-cycle drain plus completion: the output word is replaced in one edge, and WVALID stays 1 with no gap.
- RESETn asserted mid-packet discards the partial and held words. The first word sent after reset carries SOP=1.

## Test plan
- Reset check: RESETn low with random inputs -> WVALID=0, WDATA=0, S_READY=1, PKT_COUNT=0. These hold immediately on assertion, without waiting for a clock edge.
- 9-lane packet, DATA_WIDTH=4, lanes 1..9, dest 0x5A, WREADY=1 -> one word one cycle after lane 9.
  - Lane fields 9..1 from MSB down; ctrl = SOP 1, EOP 1, count 8, dest 0x5A.
  - PKT_COUNT then reads 1.
- 12-lane packet, dest 0x21 -> two words.
  - First word: SOP=1, EOP=0, count 8.
  - Second word: SOP=0, EOP=1, count 2, dest 0x21, lanes 3..8 zero. S_DEST changed mid-packet is ignored.
- Back-pressure: WREADY=0 while an 18-lane stream is offered.
  - First word is held stable.
  - S_READY drops after lane 18 completes the second word.
  - Raising WREADY for one cycle -> S_READY=1 the next cycle and WVALID stays 1 with the second word.
- Single-lane packets back-to-back, dests 0x01/0x02/0x03 -> three words, each with SOP=1, EOP=1, count 0, and PKT_COUNT=3. Preload PKT_COUNT to 0xFFFF via 65535 packets and confirm it wraps to 0.
- RESETn pulsed after 5 lanes of a packet -> no word emitted. The next 2-lane packet yields SOP=1, EOP=1, count 1.

Source files
------------

// File: rtl/netbus_lane_packer.sv
// NetBus source endpoint: packs a LAST-delimited lane stream into 9-lane NetBus
// words (SOP/EOP/count/dest header) and drives them through VALID/READY.
module netbus_lane_packer #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                       CLK,
  input  logic                       RESETn,
  input  logic [DATA_WIDTH-1:0]      S_DATA,
  input  logic                       S_LAST,
  input  logic [7:0]                 S_DEST,
  input  logic                       S_VALID,
  output logic                       S_READY,
  output logic [DATA_WIDTH*9+13:0]   WDATA,
  output logic                       WVALID,
  input  logic                       WREADY,
  output logic [15:0]                PKT_COUNT
);

  // state       | meaning
  // ST_IDLE     | accumulator empty, next lane starts a packet
  // ST_FILL     | partial word, next lane goes to r_idx
  // ST_COMPLETE | finished word waiting for the output register
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_COMPLETE
  } acc_state_t;

  localparam int LANES = 9;
  localparam int LW    = DATA_WIDTH * LANES;
  localparam int WW    = LW + 14;

  acc_state_t        r_state, w_state_nxt;
  logic [LW-1:0]     r_lanes, w_lanes_nxt, w_lanes_wr;
  logic [3:0]        r_idx, w_idx_nxt, w_wr_idx;
  logic              r_sop, w_sop_nxt, w_sop_cur;
  logic              r_eop, w_eop_nxt;
  logic [3:0]        r_cnt, w_cnt_nxt;
  logic [7:0]        r_dest, w_dest_nxt, w_dest_cur;
  logic [WW-1:0]     r_wdata, w_wdata_nxt;
  logic              r_wvalid, w_wvalid_nxt;
  logic [15:0]       r_pkt_count;
  logic              w_accept, w_out_free, w_last_lane;

  assign S_READY   = (r_state != ST_COMPLETE);
  assign WDATA     = r_wdata;
  assign WVALID    = r_wvalid;
  assign PKT_COUNT = r_pkt_count;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_state     <= ST_IDLE;
      r_lanes     <= '0;
      r_idx       <= '0;
      r_sop       <= 1'b1;
      r_eop       <= 1'b0;
      r_cnt       <= '0;
      r_dest      <= '0;
      r_wdata     <= '0;
      r_wvalid    <= 1'b0;
      r_pkt_count <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_lanes  <= w_lanes_nxt;
      r_idx    <= w_idx_nxt;
      r_sop    <= w_sop_nxt;
      r_eop    <= w_eop_nxt;
      r_cnt    <= w_cnt_nxt;
      r_dest   <= w_dest_nxt;
      r_wdata  <= w_wdata_nxt;
      r_wvalid <= w_wvalid_nxt;
      if (r_wvalid && WREADY && r_wdata[12]) begin
        r_pkt_count <= r_pkt_count + 16'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_lanes_nxt  = r_lanes;
    w_idx_nxt    = r_idx;
    w_sop_nxt    = r_sop;
    w_eop_nxt    = r_eop;
    w_cnt_nxt    = r_cnt;
    w_dest_nxt   = r_dest;
    w_wdata_nxt  = r_wdata;
    w_wvalid_nxt = r_wvalid & ~WREADY;

    w_out_free  = ~r_wvalid | WREADY;
    w_accept    = S_VALID & S_READY;
    w_wr_idx    = (r_state == ST_IDLE) ? 4'd0 : r_idx;
    w_sop_cur   = (r_state == ST_IDLE) | r_sop;
    w_dest_cur  = (r_state == ST_IDLE) ? S_DEST : r_dest;
    w_last_lane = S_LAST | (w_wr_idx == 4'd8);

    // Writing lane 0 clears the rest so unused lanes of a short word read as 0.
    w_lanes_wr = (w_wr_idx == 4'd0) ? '0 : r_lanes;
    w_lanes_wr[32'(w_wr_idx) * DATA_WIDTH +: DATA_WIDTH] = S_DATA;

    unique case (r_state)
      ST_IDLE, ST_FILL: begin
        if (w_accept) begin
          w_lanes_nxt = w_lanes_wr;
          w_dest_nxt  = w_dest_cur;
          w_sop_nxt   = w_sop_cur;
          if (w_last_lane) begin
            if (w_out_free) begin
              w_wdata_nxt  = {w_lanes_wr, w_sop_cur, S_LAST, w_wr_idx, w_dest_cur};
              w_wvalid_nxt = 1'b1;
              w_idx_nxt    = 4'd0;
              w_sop_nxt    = S_LAST;
              w_state_nxt  = S_LAST ? ST_IDLE : ST_FILL;
            end else begin
              w_eop_nxt   = S_LAST;
              w_cnt_nxt   = w_wr_idx;
              w_state_nxt = ST_COMPLETE;
            end
          end else begin
            w_idx_nxt   = w_wr_idx + 4'd1;
            w_state_nxt = ST_FILL;
          end
        end
      end
      ST_COMPLETE: begin
        if (w_out_free) begin
          w_wdata_nxt  = {r_lanes, r_sop, r_eop, r_cnt, r_dest};
          w_wvalid_nxt = 1'b1;
          w_idx_nxt    = 4'd0;
          w_sop_nxt    = r_eop;
          w_state_nxt  = r_eop ? ST_IDLE : ST_FILL;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule
